// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and the transmit state encoding used by
//                the UART transmit scheduler and its arbitration helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Payload width of one frame; the receiver expects exactly one byte.
  localparam int DATA_BITS = 8;

  // Level of the serial line when no frame is in flight (mark state).
  localparam logic TX_IDLE = 1'b1;

  // Frame sequencer states. The explicit 2-bit base keeps the encoding
  // stable across tools.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_rr_pick.sv
// ============================================================================
//  Module      : uart_rr_pick
//  Description : Combinational rotating-priority picker. The requester just
//                after 'last' (mod NREQ) has the highest priority, and 'last'
//                itself has the lowest. Reusable wherever a fair choice among
//                NREQ level requests is needed.
//  Ports       : req    - request vector, bit i = requester i pending
//                last   - index of the previous winner
//                win_id - index of the chosen requester (0 when none)
//                any    - high when at least one request is pending
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [IDW-1:0]  win_id,
  output logic            any
);

  // Rank of each requester: 0 for last+1, NREQ-1 for last itself.
  // The smallest rank among pending requesters wins.
  int w_best;
  int w_dist;

  always_comb begin
    win_id = '0;
    any    = 1'b0;
    w_best = NREQ;
    w_dist = 0;
    for (int i = 0; i < NREQ; i++) begin
      // 2*NREQ keeps the dividend non-negative for every legal 'last'.
      w_dist = (i + 2 * NREQ - 1 - int'(last)) % NREQ;
      if (req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        win_id = IDW'(i);
        any    = 1'b1;
      end
    end
  end

endmodule : uart_rr_pick

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
//  Module      : uart_tx_scheduler
//  Description : Shares one UART transmit line among NREQ byte producers.
//                A round-robin pick in IDLE captures the winner's byte and
//                the frame is serialized as: start bit, 8 data bits LSB
//                first, STOP_BITS stop bits. At least one idle cycle always
//                separates frames.
//  Ports       : outclk    - single clock, rising edge
//                reset     - asynchronous, active-low reset
//                req_valid - per-requester pending flag (level)
//                req_data  - byte i at [8i+7:8i], stable while valid
//                req_ack   - one-hot, one-cycle capture pulse
//                tx        - serial line, idles high
//                busy      - high from start bit through last stop cycle
//                grant_id  - index of the current / most recent grant
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 2
) (
  input  logic                        outclk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*DATA_BITS-1:0]   req_data,
  output logic [NREQ-1:0]             req_ack,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(NREQ)-1:0]     grant_id
);

  localparam int c_IDW = $clog2(NREQ);
  // Counters are at least one bit wide so that a parameter value of 1
  // still yields a legal vector.
  localparam int c_CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_SW  = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  localparam logic [c_CW-1:0]  c_CLK_LAST  = c_CW'(CLKS_PER_BIT - 1);
  localparam logic [c_SW-1:0]  c_STOP_LAST = c_SW'(STOP_BITS - 1);
  localparam logic [2:0]       c_BIT_LAST  = 3'(DATA_BITS - 1);
  // Reset value of the previous-grant pointer, so requester 0 ranks first.
  localparam logic [c_IDW-1:0] c_LAST_INIT = c_IDW'(NREQ - 1);

  uart_state_e            r_state;
  logic                   r_tx;
  logic                   r_busy;
  logic [NREQ-1:0]        r_ack;
  logic [c_IDW-1:0]       r_grant;
  logic [c_IDW-1:0]       r_last;
  logic [DATA_BITS-1:0]   r_shift;
  logic [2:0]             r_bit_cnt;
  logic [c_CW-1:0]        r_clk_cnt;
  logic [c_SW-1:0]        r_stop_cnt;

  logic [c_IDW-1:0]       w_win_id;
  logic                   w_any;
  logic [DATA_BITS-1:0]   w_byte;
  logic [NREQ-1:0]        w_onehot;
  logic                   w_bit_end;

  uart_rr_pick #(
    .NREQ (NREQ),
    .IDW  (c_IDW)
  ) u_pick (
    .req    (req_valid),
    .last   (r_last),
    .win_id (w_win_id),
    .any    (w_any)
  );

  // Winner byte select and ack one-hot, decoded from the picker index.
  always_comb begin
    w_byte   = '0;
    w_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(w_win_id) == i) begin
        w_byte      = req_data[i*DATA_BITS +: DATA_BITS];
        w_onehot[i] = 1'b1;
      end
    end
  end

  // Last outclk cycle of the current serial bit.
  assign w_bit_end = (r_clk_cnt == c_CLK_LAST);

  always_ff @(posedge outclk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_tx       <= TX_IDLE;
      r_busy     <= 1'b0;
      r_ack      <= '0;
      r_grant    <= '0;
      r_last     <= c_LAST_INIT;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_clk_cnt  <= '0;
      r_stop_cnt <= '0;
    end else begin
      // The ack is a single-cycle pulse issued only on the grant edge.
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          r_tx   <= TX_IDLE;
          r_busy <= 1'b0;
          // Requests are sampled here only; the grant edge already drives
          // the start bit, giving one-edge request-to-start latency.
          if (w_any) begin
            r_shift    <= w_byte;
            r_ack      <= w_onehot;
            r_grant    <= w_win_id;
            r_last     <= w_win_id;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_state    <= START;
          end
        end

        START: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_tx      <= r_shift[0];
            r_state   <= DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_cnt == c_BIT_LAST) begin
              r_tx       <= TX_IDLE;
              r_stop_cnt <= '0;
              r_state    <= STOP;
            end else begin
              // Present the next bit on the same edge that shifts it down.
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        STOP: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_stop_cnt == c_STOP_LAST) begin
              // Falling back to IDLE costs one cycle before the next
              // sample, which provides the inter-frame idle bit.
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        default: begin
          r_tx    <= TX_IDLE;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign req_ack  = r_ack;
  assign grant_id = r_grant;

endmodule : uart_tx_scheduler

`default_nettype wire
